instr_fetch: RTL and testbench

- Sequential instruction-fetch front end for the MAC accelerator. Sits directly upstream of the 4096-word instruction memory (12-bit address, 32-bit data, 1-cycle registered read).
- Drives the memory read address from a program counter and captures the returned words into a small FIFO.
- Hands instructions to the decoder over a valid/ready interface.
- Supports start, redirect (jump) and self-halt on a HALT opcode.

---
 rtl/instr_fetch_pkg.sv | 36 +++
 rtl/instr_fetch_if.sv | 44 ++++
 rtl/instr_fetch_fifo.sv | 65 ++++++
 rtl/instr_fetch.sv | 141 ++++++++++++++
 tb/tb_instr_fetch.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_pkg.sv
// -----------------------------------------------------------------------------
// instr_fetch_pkg
// Shared definitions for the instruction-fetch front end and its consumers:
//   - opcode field geometry and the HALT opcode value
//   - instruction field positions used by the downstream decoder
//   - fetch state enumeration
// No ports (package).
// -----------------------------------------------------------------------------
package instr_fetch_pkg;

  // Opcode field occupies [OPC_MSB : OPC_LSB] of every instruction word.
  localparam int OPC_MSB = 31;
  localparam int OPC_W   = 6;
  localparam int OPC_LSB = OPC_MSB - OPC_W + 1;

  // Opcode that terminates a fetch run.
  localparam logic [OPC_W-1:0] HALT_OPC = 6'h3F;

  // Operand fields as the decoder slices them (not interpreted by fetch).
  localparam int RD_MSB  = 25;
  localparam int RD_LSB  = 21;
  localparam int RS1_MSB = 20;
  localparam int RS1_LSB = 16;
  localparam int RS2_MSB = 15;
  localparam int RS2_LSB = 11;
  localparam int IMM_MSB = 10;
  localparam int IMM_LSB = 0;

  // Fetch controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

endpackage : instr_fetch_pkg

// File: rtl/instr_fetch_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_if
// Bundles the two buses of the fetch unit:
//   - instruction memory read port: imem_addr, imem_we, imem_din (from fetch),
//     imem_dout (from memory, valid the cycle after the addressing edge)
//   - decoder handshake: out_valid, out_instr, out_pc (from fetch),
//     out_ready (from decoder)
// Modports: master = fetch unit side, slave = memory/decoder side.
//
// Handshake: a transfer happens on every rising edge where out_valid and
// out_ready are both 1. While out_valid=1 and out_ready=0 the producer holds
// out_instr/out_pc stable and keeps out_valid high. out_valid never depends
// on out_ready; out_ready may depend on out_valid.
// -----------------------------------------------------------------------------
interface instr_fetch_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);

  logic [ADDR_W-1:0] imem_addr;
  logic              imem_we;
  logic [DATA_W-1:0] imem_din;
  logic [DATA_W-1:0] imem_dout;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_instr;
  logic [ADDR_W-1:0] out_pc;

  modport master (
    output imem_addr, imem_we, imem_din,
    input  imem_dout,
    output out_valid, out_instr, out_pc,
    input  out_ready
  );

  modport slave (
    input  imem_addr, imem_we, imem_din,
    output imem_dout,
    input  out_valid, out_instr, out_pc,
    output out_ready
  );

endinterface : instr_fetch_if

// File: rtl/instr_fetch_fifo.sv
// -----------------------------------------------------------------------------
// instr_fetch_fifo
// Synchronous FIFO holding {pc, instr} entries for the fetch unit.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   push, din  write an entry (accepted when not full, or full with a pop)
//   pop        remove the head (ignored when empty)
//   flush      drop all entries; wins over push/pop in the same cycle
//   dout       head entry, reads as zero when empty
//   count      number of stored entries (0..DEPTH)
//   full/empty occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module instr_fetch_fifo #(
  parameter int WIDTH = 44,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  input  logic                   flush,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO can still take a write when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop) && !flush;

  // Zero when empty so the consumer never sees stale storage.
  assign dout = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage has no reset; empty masks its contents.
  always_ff @(posedge clk) begin
    if (do_push && !rst) mem[wr_ptr] <= din;
  end

endmodule : instr_fetch_fifo

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Sequential instruction-fetch front end. Reads a 1-cycle registered
// instruction memory from a program counter, buffers returned words with the
// address they came from in a small FIFO and presents them to the decoder.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   start, start_pc  begin a fetch run at start_pc (only honoured in IDLE)
//   redirect_valid,
//   redirect_pc      jump: flush everything in flight, continue at redirect_pc
//   bus (master)     imem_addr/we/din/dout memory port, out_valid/ready/
//                    instr/pc decoder handshake
//   busy             controller not in IDLE
//   done             one-cycle pulse when the HALT instruction is accepted
//   fsm_state        current controller state (observability)
// -----------------------------------------------------------------------------
module instr_fetch
  import instr_fetch_pkg::fetch_state_t;
  import instr_fetch_pkg::IDLE;
  import instr_fetch_pkg::RUN;
  import instr_fetch_pkg::DRAIN;
#(
  parameter int              ADDR_W     = 12,
  parameter int              DATA_W     = 32,
  parameter int              FIFO_DEPTH = 4,
  parameter int              OPC_MSB    = instr_fetch_pkg::OPC_MSB,
  parameter int              OPC_W      = instr_fetch_pkg::OPC_W,
  parameter logic [OPC_W-1:0] HALT_OPC  = instr_fetch_pkg::HALT_OPC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  instr_fetch_if.master     bus,
  output logic              busy,
  output logic              done,
  output fetch_state_t      fsm_state
);

  localparam int ENT_W = ADDR_W + DATA_W;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t      state;
  fetch_state_t      state_next;

  logic [ADDR_W-1:0] pc;        // next address to issue; drives imem_addr
  logic [ADDR_W-1:0] pend_pc;   // address of the read currently in flight
  logic              pending;   // a read was issued at the previous edge

  logic              redir;
  logic              capture;
  logic              cap_halt;
  logic              credit;
  logic              issue;
  logic              pop;
  logic              head_halt;

  logic [ENT_W-1:0]  head;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;

  // Memory port: registered address only, never writes.
  assign bus.imem_addr = pc;
  assign bus.imem_we   = 1'b0;
  assign bus.imem_din  = '0;

  assign bus.out_valid = !empty;
  assign bus.out_instr = head[DATA_W-1:0];
  assign bus.out_pc    = head[ENT_W-1:DATA_W];

  assign busy      = (state != IDLE);
  assign fsm_state = state;

  always_comb begin
    state_next = state;
    redir      = redirect_valid && (state != IDLE);
    pop        = !empty && bus.out_ready;
    // Words are only kept in RUN; a redirect drops the word returning now.
    capture    = pending && (state == RUN) && !redir;
    cap_halt   = capture && (bus.imem_dout[OPC_MSB -: OPC_W] == HALT_OPC);
    // Credit: count + pending < FIFO_DEPTH, counting the in-flight read as
    // already occupying a slot so the FIFO can never overflow.
    credit     = !full && !(pending && (count == CNT_W'(FIFO_DEPTH - 1)));
    // No issue on the HALT-capture edge: nothing after HALT is wanted.
    issue      = (state == RUN) && !redir && !cap_halt && credit;
    head_halt  = (head[OPC_MSB -: OPC_W] == HALT_OPC);
    done       = (state == DRAIN) && pop && head_halt && !redir;

    case (state)
      IDLE: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        if (redir)         state_next = RUN;
        else if (cap_halt) state_next = DRAIN;
      end
      DRAIN: begin
        if (redir)     state_next = RUN;
        else if (done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pc      <= '0;
      pending <= 1'b0;
      pend_pc <= '0;
    end else begin
      state   <= state_next;
      pending <= issue;
      if (issue) pend_pc <= pc;

      if ((state == IDLE) && start) pc <= start_pc;
      else if (redir)               pc <= redirect_pc;
      else if (issue)               pc <= pc + ADDR_W'(1);  // wraps silently
    end
  end

  instr_fetch_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (capture),
    .din   ({pend_pc, bus.imem_dout}),
    .pop   (pop),
    .flush (redir),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

endmodule : instr_fetch

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
// Directed bench for instr_fetch: memory model with 1-cycle registered read,
// expected-queue scoreboard on every accepted instruction, directed checks on
// latency, backpressure, redirect, wrap, reset and ignored start.
// -----------------------------------------------------------------------------
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  localparam logic [31:0] HALT_W = 32'hFC00_0000;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [11:0]  start_pc;
  logic         redirect_valid;
  logic [11:0]  redirect_pc;
  logic         busy;
  logic         done;
  fetch_state_t fsm_state;

  always #5 clk = ~clk;

  instr_fetch_if #(.ADDR_W(12), .DATA_W(32)) bus ();

  instr_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .start_pc       (start_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus),
    .busy           (busy),
    .done           (done),
    .fsm_state      (fsm_state)
  );

  // Instruction memory model: registered read of imem_addr.
  logic [31:0] mem [4096];
  always @(posedge clk) bus.imem_dout <= mem[bus.imem_addr];

  // ---------------- scoreboard ----------------
  int          n_chk = 0;
  int          n_pass = 0;
  int          done_cnt = 0;
  bit          mon_en = 1'b0;
  logic [43:0] exp_q [$];
  logic [43:0] mon_e;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // Every accepted instruction must be the next expected {pc, instr};
  // done must fire exactly on an accepted HALT not cancelled by a redirect.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.out_valid && bus.out_ready) begin
        check("q_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("out_pc", 32'(bus.out_pc), 32'(mon_e[43:32]));
          check("out_instr", bus.out_instr, mon_e[31:0]);
          check("done", 32'(done), 32'((mon_e[31:0] == HALT_W) && !redirect_valid));
        end
      end else if (done) begin
        check("done_spurious", 32'(done), 32'd0);
      end
      if (done) done_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // n body words tag+i at base+i, then HALT at base+n; all queued as expected.
  task automatic load_run(input logic [11:0] base, input int n, input logic [31:0] tag);
    for (int i = 0; i < n; i++) begin
      mem[12'(base + 12'(i))] = tag + 32'(i);
      exp_q.push_back({12'(base + 12'(i)), tag + 32'(i)});
    end
    mem[12'(base + 12'(n))] = HALT_W;
    exp_q.push_back({12'(base + 12'(n)), HALT_W});
  endtask

  task automatic pulse_start(input logic [11:0] pc);
    start    = 1'b1;
    start_pc = pc;
    cyc(1);
    start    = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0 = done_cnt;
    int k  = 0;
    while (done_cnt == d0 && k < budget) begin
      cyc(1);
      k++;
    end
    check({tag, "_done"}, 32'(done_cnt - d0), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    for (int a = 0; a < 4096; a++) mem[a] = 32'h0;
    rst = 1'b1; start = 1'b0; start_pc = '0;
    redirect_valid = 1'b0; redirect_pc = '0;
    bus.out_ready = 1'b0;
    cyc(2);
    rst = 1'b0;

    // Reset state
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_instr", bus.out_instr, 32'd0);
    check("rst_pc", 32'(bus.out_pc), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_addr", 32'(bus.imem_addr), 32'd0);
    check("rst_we", 32'(bus.imem_we), 32'd0);
    check("rst_state", 32'(fsm_state), 32'(IDLE));

    // 1: sequential run 0..7 + HALT at 8, first valid two cycles after start
    mon_en = 1'b1;
    load_run(12'h000, 8, 32'h1000_0000);
    bus.out_ready = 1'b1;
    pulse_start(12'h000);                       // after E0
    check("lat_e0_valid", 32'(bus.out_valid), 32'd0);
    check("lat_e0_busy", 32'(busy), 32'd1);
    check("lat_e0_addr", 32'(bus.imem_addr), 32'h000);
    cyc(1);                                     // after E1
    check("lat_e1_valid", 32'(bus.out_valid), 32'd0);
    check("lat_e1_addr", 32'(bus.imem_addr), 32'h001);
    cyc(1);                                     // after E2
    check("lat_e2_valid", 32'(bus.out_valid), 32'd1);
    check("lat_e2_pc", 32'(bus.out_pc), 32'h000);
    for (int i = 1; i <= 8; i++) begin
      cyc(1);
      check("seq_no_gap", 32'(bus.out_valid), 32'd1);
    end
    check("seq_head_halt", bus.out_instr, HALT_W);
    wait_done("seq", 5);

    // 2: backpressure mid-run
    load_run(12'h020, 16, 32'h2000_0000);
    pulse_start(12'h020);                       // after E0
    cyc(3);                                     // after E3, 0x20 accepted
    bus.out_ready = 1'b0;
    cyc(3);                                     // after E6: FIFO full 0x21..0x24
    check("bp_valid", 32'(bus.out_valid), 32'd1);
    check("bp_head_pc", 32'(bus.out_pc), 32'h021);
    check("bp_head_instr", bus.out_instr, 32'h2000_0001);
    check("bp_addr", 32'(bus.imem_addr), 32'h025);
    cyc(7);                                     // after E13
    check("bp_hold_pc", 32'(bus.out_pc), 32'h021);
    check("bp_hold_instr", bus.out_instr, 32'h2000_0001);
    check("bp_hold_addr", 32'(bus.imem_addr), 32'h025);
    bus.out_ready = 1'b1;
    wait_done("bp", 40);

    // 3: redirect with 3 entries buffered and a read pending; head accepted
    //    in the redirect cycle, everything else dropped.
    for (int i = 0; i < 4; i++) mem[12'h040 + 12'(i)] = 32'h4000_0000 + 32'(i);
    exp_q.push_back({12'h040, 32'h4000_0000});
    load_run(12'h100, 4, 32'h3000_0000);
    bus.out_ready = 1'b0;
    pulse_start(12'h040);                       // after E0
    cyc(4);                                     // after E4
    check("rd_pre_head", 32'(bus.out_pc), 32'h040);
    redirect_valid = 1'b1;
    redirect_pc    = 12'h100;
    bus.out_ready  = 1'b1;
    cyc(1);                                     // after E5 (redirect edge)
    redirect_valid = 1'b0;
    check("rd_e_valid", 32'(bus.out_valid), 32'd0);
    check("rd_e_addr", 32'(bus.imem_addr), 32'h100);
    check("rd_e_state", 32'(fsm_state), 32'(RUN));
    cyc(1);
    check("rd_e1_valid", 32'(bus.out_valid), 32'd0);
    cyc(1);
    check("rd_e2_valid", 32'(bus.out_valid), 32'd1);
    check("rd_e2_pc", 32'(bus.out_pc), 32'h100);
    wait_done("rd", 30);

    // 4: wrap FFE, FFF, 000, 001, HALT at 002
    load_run(12'hFFE, 4, 32'h5000_0000);
    pulse_start(12'hFFE);
    wait_done("wrap", 30);

    // 5: reset mid-run, then a fresh start
    mon_en = 1'b0;
    pulse_start(12'h020);
    cyc(4);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check("mrst_valid", 32'(bus.out_valid), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_addr", 32'(bus.imem_addr), 32'd0);
    check("mrst_done", 32'(done), 32'd0);
    exp_q.delete();
    mon_en = 1'b1;
    load_run(12'hFFE, 4, 32'h5000_0000);
    pulse_start(12'hFFE);
    wait_done("mrst", 30);

    // 6: start during RUN is ignored
    mem[12'h200] = 32'h7700_0000;
    load_run(12'h100, 4, 32'h3000_0000);
    pulse_start(12'h100);
    cyc(2);
    start    = 1'b1;
    start_pc = 12'h200;
    cyc(1);
    start    = 1'b0;
    wait_done("ign", 30);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_instr_fetch
